// File: rtl/scan_mux_if.sv
// scan_mux_if: bundles the data, control and status signals of scan_mux.
//   din   - N packed channels of WIDTH bits, channel k at din[k*WIDTH +: WIDTH]
//   mode  - 0 manual select, 1 auto-scan
//   sel   - manual channel index
//   en    - clock enable
//   dout  - registered selected channel data
//   ch    - index of the channel held on dout
//   valid - pulse: dout/ch updated
//   wrap  - pulse: scan captured the last channel
//   err   - pulse: manual sel out of range
// master drives din/mode/sel/en; slave (the mux) drives the results.
interface scan_mux_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N     = 8
);
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] din;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               en;
  logic [WIDTH-1:0]   dout;
  logic [SEL_W-1:0]   ch;
  logic               valid;
  logic               wrap;
  logic               err;

  modport master (
    output din, mode, sel, en,
    input  dout, ch, valid, wrap, err
  );

  modport slave (
    input  din, mode, sel, en,
    output dout, ch, valid, wrap, err
  );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered N-way channel selector with manual and auto-scan modes.
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - scan_mux_if slave port (din/mode/sel/en in, dout/ch/valid/wrap/err out)
// Manual mode captures din[sel] every enabled edge. Scan mode walks channels
// 0..N-1, dwelling DWELL enabled cycles on each before capturing it.
module scan_mux #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N     = 8,
  parameter int unsigned DWELL = 1
) (
  input logic       clk,
  input logic       rst_n,
  scan_mux_if.slave bus
);

  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0] PtrMax = SEL_W'(N - 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DWELL - 1);

  typedef enum logic {StManual, StScan} state_e;

  state_e state_q, state_d;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // Channel mux. Indices with no matching channel (sel >= N) select zero and
  // report a miss, which is what flags the manual range error.
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] idx_data;
  logic             idx_hit;

  assign idx = bus.mode ? ptr_q : bus.sel;

  always_comb begin
    idx_data = '0;
    idx_hit  = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx == SEL_W'(k)) begin
        idx_data = bus.din[k*WIDTH +: WIDTH];
        idx_hit  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StManual;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: follows mode on every enabled edge
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      state_d = bus.mode ? StScan : StManual;
    end
  end

  // Output / datapath next-state
  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.en) begin
      if (!bus.mode) begin
        // Manual capture, also taken on the scan->manual edge
        dout_d  = idx_data;
        ch_d    = bus.sel;
        valid_d = 1'b1;
        err_d   = ~idx_hit;
        ptr_d   = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StManual: begin
            // Entering scan: restart at channel 0, no capture this edge
            ptr_d = '0;
            cnt_d = '0;
          end
          StScan: begin
            if (cnt_q == CntMax) begin
              dout_d  = idx_data;
              ch_d    = ptr_q;
              valid_d = 1'b1;
              wrap_d  = (ptr_q == PtrMax);
              ptr_d   = (ptr_q == PtrMax) ? '0 : ptr_q + SEL_W'(1);
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: two scan_mux instances (N=8/DWELL=1 and N=6/DWELL=3, WIDTH=4)
// checked every cycle against a channel-level model, plus directed literals.
module tb_scan_mux;

  localparam int unsigned W  = 4;
  localparam int unsigned NA = 8;
  localparam int unsigned DA = 1;
  localparam int unsigned NB = 6;
  localparam int unsigned DB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_mux_if #(.WIDTH(W), .N(NA)) if_a ();
  scan_mux_if #(.WIDTH(W), .N(NB)) if_b ();

  scan_mux #(.WIDTH(W), .N(NA), .DWELL(DA)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  scan_mux #(.WIDTH(W), .N(NB), .DWELL(DB)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: tracks whether we are scanning, which channel comes next and how
  // many enabled edges remain before it is captured.
  typedef struct {
    logic [3:0] dout;
    int         ch;
    bit         valid;
    bit         wrap;
    bit         err;
    bit         scanning;
    int         next_ch;
    int         left;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t mreset();
    mst_t r;
    r.dout = 4'h0; r.ch = 0; r.valid = 0; r.wrap = 0; r.err = 0;
    r.scanning = 0; r.next_ch = 0; r.left = 0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t s, int n, int dwell, bit en, bit mode, int sel,
                                 logic [31:0] din);
    mst_t r;
    r = s;
    r.valid = 0; r.wrap = 0; r.err = 0;
    if (!en) return r;
    if (!mode) begin
      r.scanning = 0;
      r.ch       = sel;
      r.valid    = 1;
      r.err      = (sel >= n);
      r.dout     = (sel < n) ? din[sel*4 +: 4] : 4'h0;
    end else if (!s.scanning) begin
      r.scanning = 1;
      r.next_ch  = 0;
      r.left     = dwell;
    end else begin
      r.left = s.left - 1;
      if (r.left == 0) begin
        r.dout    = din[s.next_ch*4 +: 4];
        r.ch      = s.next_ch;
        r.valid   = 1;
        r.wrap    = (s.next_ch == n - 1);
        r.next_ch = (s.next_ch + 1) % n;
        r.left    = dwell;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, NA, DA, if_a.en, if_a.mode, int'(if_a.sel), 32'(if_a.din));
      mb <= mstep(mb, NB, DB, if_b.en, if_b.mode, int'(if_b.sel), 32'(if_b.din));
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    check("a_dout",  32'(if_a.dout),  32'(ma.dout));
    check("a_ch",    32'(if_a.ch),    ma.ch);
    check("a_valid", 32'(if_a.valid), 32'(ma.valid));
    check("a_wrap",  32'(if_a.wrap),  32'(ma.wrap));
    check("a_err",   32'(if_a.err),   32'(ma.err));
    check("b_dout",  32'(if_b.dout),  32'(mb.dout));
    check("b_ch",    32'(if_b.ch),    mb.ch);
    check("b_valid", 32'(if_b.valid), 32'(mb.valid));
    check("b_wrap",  32'(if_b.wrap),  32'(mb.wrap));
    check("b_err",   32'(if_b.err),   32'(mb.err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.din = '0; if_a.mode = 1'b0; if_a.sel = '0; if_a.en = 1'b0;
    if_b.din = '0; if_b.mode = 1'b0; if_b.sel = '0; if_b.en = 1'b0;
    repeat (2) tick();
    check("rst_a_dout",  32'(if_a.dout),  32'h0);
    check("rst_a_valid", 32'(if_a.valid), 32'h0);
    check("rst_b_ch",    32'(if_b.ch),    32'h0);
    rst_n = 1'b1;
    tick();

    // Manual select on A: channels 7 and 0 hold 1, the rest 0
    if_a.din = 32'h1000_0001; if_a.en = 1'b1; if_a.sel = 3'd7;
    tick();
    check("man_dout7",  32'(if_a.dout),  32'h1);
    check("man_ch7",    32'(if_a.ch),    32'h7);
    check("man_valid7", 32'(if_a.valid), 32'h1);
    if_a.sel = 3'd1;
    tick();
    check("man_dout1", 32'(if_a.dout), 32'h0);
    check("man_ch1",   32'(if_a.ch),   32'h1);

    // Auto-scan on A, DWELL=1, channel k holds k+3
    for (int k = 0; k < 8; k++) if_a.din[k*4 +: 4] = 4'(k + 3);
    if_a.mode = 1'b1;
    tick();
    check("scan_entry_valid", 32'(if_a.valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      if_a.sel = 3'(7 - i);  // ignored while scanning
      tick();
      check("scan_dout", 32'(if_a.dout), 32'(i + 3));
      check("scan_ch",   32'(if_a.ch),   32'(i));
      check("scan_wrap", 32'(if_a.wrap), 32'(i == 7));
    end
    tick();
    check("scan_again_ch",   32'(if_a.ch),   32'h0);
    check("scan_again_wrap", 32'(if_a.wrap), 32'h0);
    if_a.en = 1'b0;
    tick();
    check("hold_valid", 32'(if_a.valid), 32'h0);
    check("hold_dout",  32'(if_a.dout),  32'h3);
    // Scan->manual edge captures the manual channel immediately
    if_a.en = 1'b1; if_a.mode = 1'b0; if_a.sel = 3'd2;
    tick();
    check("s2m_dout", 32'(if_a.dout), 32'h5);
    check("s2m_ch",   32'(if_a.ch),   32'h2);
    if_a.en = 1'b0;

    // Manual range error on B (N=6), channel k holds 9+k
    for (int k = 0; k < 6; k++) if_b.din[k*4 +: 4] = 4'(9 + k);
    if_b.en = 1'b1; if_b.sel = 3'd6;
    tick();
    check("err_flag",  32'(if_b.err),   32'h1);
    check("err_dout",  32'(if_b.dout),  32'h0);
    check("err_ch",    32'(if_b.ch),    32'h6);
    check("err_valid", 32'(if_b.valid), 32'h1);
    if_b.sel = 3'd5;
    tick();
    check("ok_err",  32'(if_b.err),  32'h0);
    check("ok_dout", 32'(if_b.dout), 32'he);

    // Scan on B with DWELL=3 and en pattern 1,0,1,1 after the transition
    if_b.mode = 1'b1;
    tick();
    tick();
    check("dw1_valid", 32'(if_b.valid), 32'h0);
    if_b.en = 1'b0;
    tick();
    check("dw_off_valid", 32'(if_b.valid), 32'h0);
    check("dw_off_dout",  32'(if_b.dout),  32'he);
    if_b.din[3:0] = 4'h7;  // changes between captures never show until capture
    if_b.en = 1'b1;
    tick();
    check("dw2_valid", 32'(if_b.valid), 32'h0);
    check("dw2_dout",  32'(if_b.dout),  32'he);
    tick();
    check("dw3_valid", 32'(if_b.valid), 32'h1);
    check("dw3_ch",    32'(if_b.ch),    32'h0);
    check("dw3_dout",  32'(if_b.dout),  32'h7);
    repeat (18) tick();
    check("b_round_ch", 32'(if_b.ch), 32'h0);
    repeat (12) tick();
    check("b_mid_ch", 32'(if_b.ch), 32'h4);
    tick();

    // Async reset pulse between edges
    #1 rst_n = 1'b0;
    #1;
    check("arst_dout",  32'(if_b.dout),  32'h0);
    check("arst_ch",    32'(if_b.ch),    32'h0);
    check("arst_valid", 32'(if_b.valid), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_entry", 32'(if_b.valid), 32'h0);
    repeat (2) tick();
    check("post_rst_wait", 32'(if_b.valid), 32'h0);
    tick();
    check("post_rst_valid", 32'(if_b.valid), 32'h1);
    check("post_rst_ch",    32'(if_b.ch),    32'h0);
    check("post_rst_wrap",  32'(if_b.wrap),  32'h0);
    check("post_rst_dout",  32'(if_b.dout),  32'h7);

    if_b.en = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
